// File: rtl/gate_checker.sv
// gate_checker: response checker for a two-input logic gate under test.
//
// Samples A_IN/B_IN/Y_IN on VALID through a two-stage pipeline. Each checked
// sample is compared with the gate function latched at START. The block
// counts mismatches (saturating), records {A,B} truth-table coverage and
// issues one pass/fail verdict when coverage completes or the run times out.
//
// Parameters:
//   CNT_W     width of the mismatch counter
//   TIMEOUT   cycles allowed in RUN before a forced fail (>= 8)
//
// Ports:
//   CLK, RST_N       clock (rising edge), asynchronous active-low reset
//   START            one-cycle pulse: latch FUNC, clear results, enter RUN
//   FUNC[2:0]        0 OR, 1 AND, 2 XOR, 3 NOR, 4 NAND, 5 XNOR, 6-7 OR
//   VALID            sample strobe for A_IN/B_IN/Y_IN
//   A_IN, B_IN, Y_IN gate inputs as driven and gate output
//   BUSY             high while in RUN
//   DONE             one-cycle pulse on entering DONE
//   PASS             verdict, held until the next START
//   TIMED_OUT        run ended by timeout, held
//   MISMATCH         one-cycle pulse per failing sample
//   ERR_CNT          saturating mismatch count
//   COVER[3:0]       bit {A,B} set once that combination has been checked
//   FAIL_VEC[2:0]    {A,B,Y} of the first mismatch
//
// Optional feature macro: GATE_CHECKER_FAIL_CAPTURE_EN
//   defined   -> FAIL_VEC holds {A,B,Y} of the first mismatch after START
//   undefined -> no capture register, FAIL_VEC reads 3'b000

module gate_checker #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [2:0]       FUNC,
    input  logic             VALID,
    input  logic             A_IN,
    input  logic             B_IN,
    input  logic             Y_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic             TIMED_OUT,
    output logic             MISMATCH,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [3:0]       COVER,
    output logic [2:0]       FAIL_VEC
);

    localparam int unsigned      TMR_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] ERR_MAX  = '1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   timeout_hit;

    // Latched function and run timer
    logic [2:0]       func_q;
    logic [2:0]       func_d;
    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] tmr_d;

    // Stage 1 sample register
    logic s1_valid;
    logic s1_a;
    logic s1_b;
    logic s1_y;
    logic s1_valid_d;
    logic s1_a_d;
    logic s1_b_d;
    logic s1_y_d;

    // Next values of the registered outputs
    logic             busy_d;
    logic             done_d;
    logic             pass_d;
    logic             timed_out_d;
    logic             mismatch_d;
    logic [CNT_W-1:0] err_d;
    logic [3:0]       cover_d;

`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
    logic [2:0] fail_q;
    logic [2:0] fail_d;
`endif

    logic [1:0] sample_idx;
    logic       sample_bad;

    // Reference gate function; codes 6 and 7 fall back to OR
    function automatic logic expected_y(input logic [2:0] f, input logic a, input logic b);
        logic y;
        case (f)
            3'd1:    y = a & b;
            3'd2:    y = a ^ b;
            3'd3:    y = ~(a | b);
            3'd4:    y = ~(a & b);
            3'd5:    y = ~(a ^ b);
            default: y = a | b;
        endcase
        return y;
    endfunction

    // Stage 2 compare of the sample held in stage 1
    assign sample_idx = {s1_a, s1_b};
    assign sample_bad = (s1_y != expected_y(func_q, s1_a, s1_b));

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; completed coverage takes priority over the timeout
    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (START) begin
                    state_d = ST_RUN;
                end else if (COVER == 4'hF) begin
                    state_d = ST_DONE;
                end else if (tmr_q == TMR_LAST) begin
                    state_d     = ST_DONE;
                    timeout_hit = 1'b1;
                end
            end
            ST_DONE: begin
                if (START) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next-value logic
    always_comb begin
        busy_d      = (state_d == ST_RUN);
        done_d      = 1'b0;
        pass_d      = PASS;
        timed_out_d = TIMED_OUT;
        mismatch_d  = 1'b0;
        err_d       = ERR_CNT;
        cover_d     = COVER;
        tmr_d       = tmr_q;
        func_d      = func_q;
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
        fail_d      = fail_q;
`endif

        // Stage 1 only fills while the run continues; START flushes it
        s1_valid_d = VALID && !START && (state_q == ST_RUN) && (state_d == ST_RUN);
        s1_a_d     = A_IN;
        s1_b_d     = B_IN;
        s1_y_d     = Y_IN;

        if (START) begin
            pass_d      = 1'b0;
            timed_out_d = 1'b0;
            err_d       = '0;
            cover_d     = '0;
            tmr_d       = '0;
            func_d      = FUNC;
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
            fail_d      = '0;
`endif
        end else if (state_q == ST_RUN) begin
            if (state_d == ST_DONE) begin
                // Leaving RUN: the sample in stage 1 is dropped
                done_d      = 1'b1;
                pass_d      = !timeout_hit && (ERR_CNT == '0);
                timed_out_d = timeout_hit;
            end else begin
                tmr_d = tmr_q + TMR_W'(1);
                if (s1_valid) begin
                    cover_d[sample_idx] = 1'b1;
                    if (sample_bad) begin
                        mismatch_d = 1'b1;
                        if (ERR_CNT != ERR_MAX) begin
                            err_d = ERR_CNT + CNT_W'(1);
                        end
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
                        // A zero count means no mismatch seen since START
                        if (ERR_CNT == '0) begin
                            fail_d = {s1_a, s1_b, s1_y};
                        end
`endif
                    end
                end
            end
        end
    end

    // Output, pipeline and control registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
            TIMED_OUT <= 1'b0;
            MISMATCH  <= 1'b0;
            ERR_CNT   <= '0;
            COVER     <= '0;
            tmr_q     <= '0;
            func_q    <= '0;
            s1_valid  <= 1'b0;
            s1_a      <= 1'b0;
            s1_b      <= 1'b0;
            s1_y      <= 1'b0;
        end else begin
            BUSY      <= busy_d;
            DONE      <= done_d;
            PASS      <= pass_d;
            TIMED_OUT <= timed_out_d;
            MISMATCH  <= mismatch_d;
            ERR_CNT   <= err_d;
            COVER     <= cover_d;
            tmr_q     <= tmr_d;
            func_q    <= func_d;
            s1_valid  <= s1_valid_d;
            s1_a      <= s1_a_d;
            s1_b      <= s1_b_d;
            s1_y      <= s1_y_d;
        end
    end

`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
    // First-mismatch capture
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fail_q <= '0;
        end else begin
            fail_q <= fail_d;
        end
    end

    assign FAIL_VEC = fail_q;
`else
    assign FAIL_VEC = 3'b000;
`endif

endmodule

// File: tb/tb_gate_checker.sv
// tb_gate_checker: directed and randomized bench for gate_checker.
// Two instances share all stimulus: default CNT_W and CNT_W = 2 (saturation).
// Expected values come from a run-level model over the stimulus table.

module tb_gate_checker;

    localparam int unsigned TIMEOUT = 64;
    localparam int          MAXD    = 80;
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] func;
    logic       valid;
    logic       a_in;
    logic       b_in;
    logic       y_in;

    logic       busy, done, pass, timed_out, mismatch;
    logic [7:0] err_cnt;
    logic [3:0] cov;
    logic [2:0] fail_vec;

    logic       s_busy, s_done, s_pass, s_timed_out, s_mismatch;
    logic [1:0] s_err_cnt;
    logic [3:0] s_cov;
    logic [2:0] s_fail_vec;

    gate_checker #(.CNT_W(8), .TIMEOUT(TIMEOUT)) dut (
        .CLK(clk), .RST_N(rst_n), .START(start), .FUNC(func), .VALID(valid),
        .A_IN(a_in), .B_IN(b_in), .Y_IN(y_in),
        .BUSY(busy), .DONE(done), .PASS(pass), .TIMED_OUT(timed_out),
        .MISMATCH(mismatch), .ERR_CNT(err_cnt), .COVER(cov), .FAIL_VEC(fail_vec)
    );

    gate_checker #(.CNT_W(2), .TIMEOUT(TIMEOUT)) dut_sat (
        .CLK(clk), .RST_N(rst_n), .START(start), .FUNC(func), .VALID(valid),
        .A_IN(a_in), .B_IN(b_in), .Y_IN(y_in),
        .BUSY(s_busy), .DONE(s_done), .PASS(s_pass), .TIMED_OUT(s_timed_out),
        .MISMATCH(s_mismatch), .ERR_CNT(s_err_cnt), .COVER(s_cov), .FAIL_VEC(s_fail_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cur_j = 0;

    // Stimulus table: sample driven for capture at edge START+d
    bit sv [0:MAXD];
    bit sa [0:MAXD];
    bit sb [0:MAXD];
    bit sy [0:MAXD];

    // Model results: state after edge START+j
    int e_cov [0:MAXD];
    int e_cnt [0:MAXD];
    int e_mm  [0:MAXD];
    int e_fv  [0:MAXD];
    int done_edge;
    bit m_pass;
    bit m_timed;

    // Truth tables indexed by {a,b}
    function automatic bit gate_ref(input logic [2:0] f, input bit a, input bit b);
        logic [3:0] tt;
        case (f)
            3'd1:    tt = 4'b1000;
            3'd2:    tt = 4'b0110;
            3'd3:    tt = 4'b0001;
            3'd4:    tt = 4'b0111;
            3'd5:    tt = 4'b1001;
            default: tt = 4'b1110;
        endcase
        return tt[{a, b}];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s at j=%0d: observed %0h, required %0h", tag, cur_j, obs, exp_v);
        end
    endtask

    // Walk the samples in order: a sample sent at offset d is judged at edge
    // d+1, only while the run lasts (before edge TIMEOUT, before completion).
    task automatic model(input logic [2:0] f);
        int c;
        int n;
        int comp;
        int fv;
        c = 0; n = 0; comp = -1; fv = 0;
        for (int j = 0; j <= MAXD; j++) begin
            e_mm[j] = 0;
            if (j >= 2 && comp < 0 && j <= int'(TIMEOUT) - 1 && sv[j-1]) begin
                c = c | (1 << (2 * int'(sa[j-1]) + int'(sb[j-1])));
                if (sy[j-1] != gate_ref(f, sa[j-1], sb[j-1])) begin
                    if (n == 0) fv = 4 * int'(sa[j-1]) + 2 * int'(sb[j-1]) + int'(sy[j-1]);
                    n++;
                    e_mm[j] = 1;
                end
                if (c == 15) comp = j;
            end
            e_cov[j] = c;
            e_cnt[j] = n;
            e_fv[j]  = fv;
        end
        if (comp >= 0) begin
            done_edge = comp + 1;
            m_timed   = 1'b0;
            m_pass    = (n == 0);
        end else begin
            done_edge = int'(TIMEOUT);
            m_timed   = 1'b1;
            m_pass    = 1'b0;
        end
    endtask

    task automatic check_edge(input int j);
        int  n;
        bit  xb;
        bit  xd;
        bit  xp;
        bit  xt;
        int  xfv;
        cur_j = j;
        n   = e_cnt[j];
        xb  = (j < done_edge);
        xd  = (j == done_edge);
        xp  = (j >= done_edge) && m_pass;
        xt  = (j >= done_edge) && m_timed;
        xfv = CAP ? e_fv[j] : 0;
        chk("busy",      32'(busy),      32'(xb));
        chk("done",      32'(done),      32'(xd));
        chk("pass",      32'(pass),      32'(xp));
        chk("timed_out", 32'(timed_out), 32'(xt));
        chk("mismatch",  32'(mismatch),  32'(e_mm[j]));
        chk("err_cnt",   32'(err_cnt),   32'((n > 255) ? 255 : n));
        chk("cover",     32'(cov),       32'(e_cov[j]));
        chk("fail_vec",  32'(fail_vec),  32'(xfv));
        chk("s_busy",    32'(s_busy),    32'(xb));
        chk("s_done",    32'(s_done),    32'(xd));
        chk("s_pass",    32'(s_pass),    32'(xp));
        chk("s_mismatch", 32'(s_mismatch), 32'(e_mm[j]));
        chk("s_err_cnt", 32'(s_err_cnt), 32'((n > 3) ? 3 : n));
        chk("s_cover",   32'(s_cov),     32'(e_cov[j]));
    endtask

    task automatic check_all_zero(input string tag);
        cur_j = -1;
        chk({tag, ".busy"},      32'(busy),      32'd0);
        chk({tag, ".done"},      32'(done),      32'd0);
        chk({tag, ".pass"},      32'(pass),      32'd0);
        chk({tag, ".timed_out"}, 32'(timed_out), 32'd0);
        chk({tag, ".mismatch"},  32'(mismatch),  32'd0);
        chk({tag, ".err_cnt"},   32'(err_cnt),   32'd0);
        chk({tag, ".cover"},     32'(cov),       32'd0);
        chk({tag, ".fail_vec"},  32'(fail_vec),  32'd0);
        chk({tag, ".s_busy"},    32'(s_busy),    32'd0);
        chk({tag, ".s_done"},    32'(s_done),    32'd0);
        chk({tag, ".s_err_cnt"}, 32'(s_err_cnt), 32'd0);
        chk({tag, ".s_cover"},   32'(s_cov),     32'd0);
    endtask

    task automatic clear_stim();
        for (int d = 0; d <= MAXD; d++) begin
            sv[d] = 1'b0;
            sa[d] = 1'($urandom);
            sb[d] = 1'($urandom);
            sy[d] = 1'($urandom);
        end
    endtask

    task automatic set_s(input int d, input bit a, input bit b, input bit y);
        sv[d] = 1'b1;
        sa[d] = a;
        sb[d] = b;
        sy[d] = y;
    endtask

    task automatic fill_rand(input logic [2:0] f, input int vpct, input int epct);
        for (int d = 0; d <= MAXD; d++) begin
            sv[d] = ($urandom_range(99) < vpct);
            sa[d] = 1'($urandom);
            sb[d] = 1'($urandom);
            sy[d] = gate_ref(f, sa[d], sb[d]) ^ ($urandom_range(99) < epct);
        end
    endtask

    // Pulse START (with a junk VALID that must be flushed), then drive the
    // table and check every cycle; jstop >= 0 truncates the run.
    task automatic run_case(input logic [2:0] f, input int jstop);
        int jend;
        model(f);
        jend = (jstop >= 0) ? jstop : done_edge + 2;
        @(negedge clk);
        start = 1'b1;
        func  = f;
        valid = 1'b1;
        a_in  = 1'($urandom);
        b_in  = 1'($urandom);
        y_in  = 1'($urandom);
        @(posedge clk);
        for (int j = 0; j <= jend; j++) begin
            @(negedge clk);
            start = 1'b0;
            check_edge(j);
            func  = 3'($urandom);
            valid = sv[j+1];
            a_in  = sa[j+1];
            b_in  = sb[j+1];
            y_in  = sy[j+1];
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dens;
        int errp;
        int js;
        logic [2:0] f;

        rst_n = 1'b0; start = 1'b0; func = 3'd0; valid = 1'b0;
        a_in = 1'b0; b_in = 1'b0; y_in = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1; a_in = 1'($urandom); b_in = 1'($urandom); y_in = 1'($urandom);
            @(negedge clk);
            check_all_zero("idle");
        end

        // OR, all correct
        clear_stim();
        set_s(1, 0, 0, 0); set_s(2, 0, 1, 1); set_s(3, 1, 0, 1); set_s(4, 1, 1, 1);
        run_case(3'd0, -1);

        // AND with the OR vectors: {0,1} and {1,0} fail
        run_case(3'd1, -1);

        // XOR timeout with only {0,0} and {1,1}
        clear_stim();
        set_s(1, 0, 0, 0); set_s(2, 1, 1, 0);
        run_case(3'd2, -1);

        // NOR: five wrong {0,0} then the rest correct
        clear_stim();
        for (int d = 1; d <= 5; d++) set_s(d, 0, 0, 0);
        set_s(6, 0, 1, 0); set_s(7, 1, 0, 0); set_s(8, 1, 1, 0);
        run_case(3'd3, -1);

        // Restart mid-run, then NAND checking
        clear_stim();
        set_s(1, 0, 1, 1); set_s(2, 1, 1, 1); set_s(4, 0, 0, 0);
        run_case(3'd1, 3);
        clear_stim();
        set_s(1, 0, 0, 1); set_s(2, 0, 1, 1); set_s(3, 1, 0, 1); set_s(4, 1, 1, 1);
        run_case(3'd4, -1);

        // Randomized runs, some truncated by a restart
        for (int r = 0; r < 24; r++) begin
            f = 3'($urandom_range(7));
            case ($urandom_range(2))
                0:       dens = 100;
                1:       dens = 50;
                default: dens = 6;
            endcase
            case ($urandom_range(2))
                0:       errp = 0;
                1:       errp = 10;
                default: errp = 40;
            endcase
            js = ($urandom_range(3) == 0) ? int'($urandom_range(1, 10)) : -1;
            fill_rand(f, dens, errp);
            run_case(f, js);
        end

        // Reset in the middle of a run
        fill_rand(3'd2, 100, 30);
        run_case(3'd2, 3);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        check_all_zero("in_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid = 1'b1; a_in = 1'($urandom); b_in = 1'($urandom); y_in = 1'($urandom);
            @(negedge clk);
            check_all_zero("after_reset");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gate_checker.md
# gate_checker

Synthesizable response checker for two-input logic gates. It is the consuming end of a gate test bench. A stimulus source drives A/B into a gate DUT; this block samples those inputs together with the DUT output Y on a valid strobe. It compares each sample against the expected function, counts mismatches and tracks truth-table coverage, then reports a single pass/fail verdict. One instance sits beside each gate under test.

## Interface
Parameters:
- CNT_W, 8, width of the error counter.
- TIMEOUT, 64, maximum cycles spent in RUN before a forced fail (≥ 8).

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle pulse; latches FUNC, clears results, enters RUN.
- FUNC  in  3  expected function: 0 OR, 1 AND, 2 XOR, 3 NOR, 4 NAND, 5 XNOR; 6–7 are treated as OR.
- VALID  in  1  sample strobe for A_IN/B_IN/Y_IN.
- A_IN  in  1  DUT input A as driven.
- B_IN  in  1  DUT input B as driven.
- Y_IN  in  1  DUT output Y.
- BUSY  out  1  high in RUN.
- DONE  out  1  one-cycle pulse on entering DONE.
- PASS  out  1  verdict, held until next START.
- TIMED_OUT  out  1  high if RUN ended by timeout, held.
- MISMATCH  out  1  one-cycle pulse per failing sample.
- ERR_CNT  out  CNT_W  saturating mismatch count.
- COVER  out  4  bit {A,B} set once that combination has been checked.
- FAIL_VEC  out  3  {A,B,Y} of first mismatch (see Configuration).

## Operation
- States are IDLE, RUN and DONE.
- IDLE:
  - START moves to RUN.
  - VALID is ignored.
- RUN:
  - Stage 1 registers VALID, A_IN, B_IN and Y_IN every cycle.
  - Stage 2 acts when registered VALID is 1. It sets COVER[{A,B}] and computes expected = f_FUNC(A,B).
  - On mismatch: pulse MISMATCH and increment ERR_CNT, saturating at 2^CNT_W−1.
  - When COVER becomes 4'hF, go to DONE. PASS = (ERR_CNT == 0), including any mismatch in the completing sample.
  - The timeout counter increments every RUN cycle. On reaching TIMEOUT−1 with COVER ≠ 4'hF: go to DONE with PASS = 0 and TIMED_OUT = 1.
  - If coverage completes in the same cycle as the timeout, coverage wins: TIMED_OUT = 0.
- DONE:
  - All outputs hold.
  - VALID is ignored.
  - START returns to RUN with everything cleared.
- START while in RUN restarts: counters, COVER and FAIL_VEC clear, FUNC is re-latched, and the pipeline is flushed.
- FUNC is sampled only on START; changes during RUN have no effect.
- Repeated samples of an already-covered combination are still checked and counted.

## Timing
- Reset value of every output is 0, and the state is IDLE. Reset mid-RUN aborts immediately; no DONE pulse is issued.
- START at edge n: BUSY = 1 after edge n. A VALID sampled at edge n+1 or later counts.
- Sample latency: VALID sampled at edge k makes MISMATCH, ERR_CNT and COVER visible after edge k+1.
- DONE pulses, and PASS becomes valid, one cycle after the COVER update that completes coverage. BUSY falls in that same cycle.
- Back-to-back VALID is accepted every cycle with no stall.
- Samples still in stage 1 when DONE is entered are discarded.
- Timeout: with no VALID, DONE pulses TIMEOUT cycles after START.

## Configuration
- Macro: GATE_CHECKER_FAIL_CAPTURE_EN.
- Defined: FAIL_VEC captures {A,B,Y} of the first mismatching sample after START and holds it until the next START or reset. Later mismatches do not overwrite it.
- Undefined: the capture register is absent and FAIL_VEC is tied to 3'b000. All other behaviour is identical.

## Test plan
- OR pass: START with FUNC = 0. Drive VALID with (A,B,Y) = (0,0,0), (0,1,1), (1,0,1), (1,1,1) on consecutive cycles. Expect DONE 2 cycles after the last VALID, PASS = 1, ERR_CNT = 0, COVER = 4'hF.
- AND fault: START with FUNC = 1. Drive the same four vectors as the OR case. Expect MISMATCH pulses for {0,1} and {1,0}, ERR_CNT = 2, PASS = 0. With the macro defined, FAIL_VEC = 3'b011.
- Timeout: START with FUNC = 2, drive only {0,0} and {1,1} correctly. Expect DONE after 64 cycles, PASS = 0, TIMED_OUT = 1, COVER = 4'b1001.
- Saturation and repeats: with CNT_W = 2 and FUNC = 3, drive 5 wrong {0,0} samples, then the remaining combinations correctly. Expect ERR_CNT = 3 (saturated), PASS = 0.
- Restart and reset: START, then 2 vectors, then START again with FUNC = 4. Expect ERR_CNT and COVER cleared and NAND checking in force. Assert RST_N low mid-RUN: expect all outputs 0 asynchronously and no DONE pulse.
